// File: rtl/slv_axi_rd_reg_slice.sv
// slv_axi_rd_reg_slice: registered AR/R skid slices with an outstanding-read limit
module slv_axi_rd_reg_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         mv_q, mv_d, sv_q, sv_d, acc, free;
  assign in_ready_o  = !sv_q;
  assign out_data_o  = main_q;
  assign out_valid_o = mv_q;
  assign acc         = in_valid_i && !sv_q;
  assign free        = !mv_q || out_ready_i;
  // main refills from skid first, else from input; skid only fills behind a stalled main
  always_comb begin
    mv_d   = free ? (sv_q || acc) : 1'b1;
    main_d = !free ? main_q : (sv_q ? skid_q : in_data_i);
    sv_d   = free ? 1'b0 : (sv_q || acc);
    skid_d = (!free && acc) ? in_data_i : skid_q;
  end
  // valid flags
  always_ff @(posedge clk) begin
    if (rst) begin
      mv_q <= 1'b0;
      sv_q <= 1'b0;
    end else begin
      mv_q <= mv_d;
      sv_q <= sv_d;
    end
  end
  // payload registers, meaningless while their valid is low
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end
endmodule

module slv_axi_rd_reg_slice #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int MAX_TRANS  = 8
) (
  input  logic                  ACLK,
  input  logic                  sysReset,
  input  logic [ID_WIDTH-1:0]   conv_ARID,
  input  logic [ADDR_WIDTH-1:0] conv_ARADDR,
  input  logic [7:0]            conv_ARLEN,
  input  logic [2:0]            conv_ARSIZE,
  input  logic [1:0]            conv_ARBURST,
  input  logic [1:0]            conv_ARLOCK,
  input  logic [2:0]            conv_ARPROT,
  input  logic [3:0]            conv_ARCACHE,
  input  logic                  conv_ARVALID,
  output logic                  conv_ARREADY,
  output logic [ID_WIDTH-1:0]   SLAVE_ARID,
  output logic [ADDR_WIDTH-1:0] SLAVE_ARADDR,
  output logic [7:0]            SLAVE_ARLEN,
  output logic [2:0]            SLAVE_ARSIZE,
  output logic [1:0]            SLAVE_ARBURST,
  output logic [1:0]            SLAVE_ARLOCK,
  output logic [2:0]            SLAVE_ARPROT,
  output logic [3:0]            SLAVE_ARCACHE,
  output logic                  SLAVE_ARVALID,
  input  logic                  SLAVE_ARREADY,
  input  logic [ID_WIDTH-1:0]   SLAVE_RID,
  input  logic [DATA_WIDTH-1:0] SLAVE_RDATA,
  input  logic [1:0]            SLAVE_RRESP,
  input  logic                  SLAVE_RLAST,
  input  logic                  SLAVE_RVALID,
  output logic                  SLAVE_RREADY,
  output logic [ID_WIDTH-1:0]   conv_RID,
  output logic [DATA_WIDTH-1:0] conv_RDATA,
  output logic [1:0]            conv_RRESP,
  output logic                  conv_RLAST,
  output logic                  conv_RVALID,
  input  logic                  conv_RREADY
);
  localparam int ARW = ID_WIDTH + ADDR_WIDTH + 22;
  localparam int RW  = ID_WIDTH + DATA_WIDTH + 3;
  localparam int CW  = $clog2(MAX_TRANS + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_TRANS);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ar_in_ready, lim_ok, inc, dec;
  assign lim_ok       = cnt_q < MAXC;
  assign conv_ARREADY = ar_in_ready && lim_ok;
  assign inc          = conv_ARVALID && conv_ARREADY;
  assign dec          = conv_RVALID && conv_RREADY && conv_RLAST;
  slv_axi_rd_reg_slice_skid #(.W(ARW)) u_ar (
    .clk         (ACLK),
    .rst         (sysReset),
    .in_data_i   ({conv_ARID, conv_ARADDR, conv_ARLEN, conv_ARSIZE,
                   conv_ARBURST, conv_ARLOCK, conv_ARPROT, conv_ARCACHE}),
    .in_valid_i  (conv_ARVALID && lim_ok),
    .in_ready_o  (ar_in_ready),
    .out_data_o  ({SLAVE_ARID, SLAVE_ARADDR, SLAVE_ARLEN, SLAVE_ARSIZE,
                   SLAVE_ARBURST, SLAVE_ARLOCK, SLAVE_ARPROT, SLAVE_ARCACHE}),
    .out_valid_o (SLAVE_ARVALID),
    .out_ready_i (SLAVE_ARREADY)
  );
  slv_axi_rd_reg_slice_skid #(.W(RW)) u_r (
    .clk         (ACLK),
    .rst         (sysReset),
    .in_data_i   ({SLAVE_RID, SLAVE_RDATA, SLAVE_RRESP, SLAVE_RLAST}),
    .in_valid_i  (SLAVE_RVALID),
    .in_ready_o  (SLAVE_RREADY),
    .out_data_o  ({conv_RID, conv_RDATA, conv_RRESP, conv_RLAST}),
    .out_valid_o (conv_RVALID),
    .out_ready_i (conv_RREADY)
  );
  // outstanding bursts: AR accept adds one, final R beat removes one, floor at zero
  always_comb begin
    cnt_d = (inc && !dec) ? cnt_q + CW'(1) : (dec && !inc && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  end
  // outstanding counter register
  always_ff @(posedge ACLK) begin
    if (sysReset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`ifndef SYNTHESIS
  // an RLAST with nothing outstanding means the slave broke protocol
  always_ff @(posedge ACLK) begin
    if (!sysReset) assert (!(dec && !inc && cnt_q == '0)) else $error("RLAST with no outstanding read");
  end
`endif
endmodule

// File: tb/tb_slv_axi_rd_reg_slice.sv
// tb_slv_axi_rd_reg_slice: scoreboard bench for the read register slice
module tb_slv_axi_rd_reg_slice;
  localparam int AW = 20, DW = 32, IW = 2;
  logic ACLK, sysReset;
  logic [IW-1:0] conv_ARID;
  logic [AW-1:0] conv_ARADDR;
  logic [7:0] conv_ARLEN;
  logic [2:0] conv_ARSIZE, conv_ARPROT;
  logic [1:0] conv_ARBURST, conv_ARLOCK;
  logic [3:0] conv_ARCACHE;
  logic conv_ARVALID, SLAVE_ARREADY, SLAVE_RVALID, SLAVE_RLAST, conv_RREADY;
  logic [IW-1:0] SLAVE_RID;
  logic [DW-1:0] SLAVE_RDATA;
  logic [1:0] SLAVE_RRESP;
  wire conv_ARREADY, SLAVE_ARVALID, SLAVE_RREADY, conv_RVALID, conv_RLAST;
  wire [IW-1:0] SLAVE_ARID, conv_RID;
  wire [AW-1:0] SLAVE_ARADDR;
  wire [7:0] SLAVE_ARLEN;
  wire [2:0] SLAVE_ARSIZE, SLAVE_ARPROT;
  wire [1:0] SLAVE_ARBURST, SLAVE_ARLOCK, conv_RRESP;
  wire [3:0] SLAVE_ARCACHE;
  wire [DW-1:0] conv_RDATA;
  logic m_ARVALID, m_SARREADY, m_SRVALID, m_RREADY;
  wire m_ARREADY, m_SARVALID, m_SRREADY, m_RVALID, m_RLAST;
  wire [IW-1:0] m_SARID, m_RID;
  wire [AW-1:0] m_SARADDR;
  wire [7:0] m_SARLEN;
  wire [2:0] m_SARSIZE, m_SARPROT;
  wire [1:0] m_SARBURST, m_SARLOCK, m_RRESP;
  wire [3:0] m_SARCACHE;
  wire [DW-1:0] m_RDATA;
  int pass_n = 0, tot_n = 0, r_delivered = 0;
  logic [IW+AW+21:0] ar_q[$], ae;
  logic [IW+DW+2:0] r_q[$], re;
  wire [IW+AW+21:0] ar_in  = {conv_ARID, conv_ARADDR, conv_ARLEN, conv_ARSIZE, conv_ARBURST, conv_ARLOCK, conv_ARPROT, conv_ARCACHE};
  wire [IW+AW+21:0] ar_out = {SLAVE_ARID, SLAVE_ARADDR, SLAVE_ARLEN, SLAVE_ARSIZE, SLAVE_ARBURST, SLAVE_ARLOCK, SLAVE_ARPROT, SLAVE_ARCACHE};
  wire [IW+DW+2:0] r_in  = {SLAVE_RID, SLAVE_RDATA, SLAVE_RRESP, SLAVE_RLAST};
  wire [IW+DW+2:0] r_out = {conv_RID, conv_RDATA, conv_RRESP, conv_RLAST};

  slv_axi_rd_reg_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_TRANS(8)) dut (
    .ACLK(ACLK), .sysReset(sysReset),
    .conv_ARID(conv_ARID), .conv_ARADDR(conv_ARADDR), .conv_ARLEN(conv_ARLEN), .conv_ARSIZE(conv_ARSIZE),
    .conv_ARBURST(conv_ARBURST), .conv_ARLOCK(conv_ARLOCK), .conv_ARPROT(conv_ARPROT), .conv_ARCACHE(conv_ARCACHE),
    .conv_ARVALID(conv_ARVALID), .conv_ARREADY(conv_ARREADY),
    .SLAVE_ARID(SLAVE_ARID), .SLAVE_ARADDR(SLAVE_ARADDR), .SLAVE_ARLEN(SLAVE_ARLEN), .SLAVE_ARSIZE(SLAVE_ARSIZE),
    .SLAVE_ARBURST(SLAVE_ARBURST), .SLAVE_ARLOCK(SLAVE_ARLOCK), .SLAVE_ARPROT(SLAVE_ARPROT), .SLAVE_ARCACHE(SLAVE_ARCACHE),
    .SLAVE_ARVALID(SLAVE_ARVALID), .SLAVE_ARREADY(SLAVE_ARREADY),
    .SLAVE_RID(SLAVE_RID), .SLAVE_RDATA(SLAVE_RDATA), .SLAVE_RRESP(SLAVE_RRESP), .SLAVE_RLAST(SLAVE_RLAST),
    .SLAVE_RVALID(SLAVE_RVALID), .SLAVE_RREADY(SLAVE_RREADY),
    .conv_RID(conv_RID), .conv_RDATA(conv_RDATA), .conv_RRESP(conv_RRESP), .conv_RLAST(conv_RLAST),
    .conv_RVALID(conv_RVALID), .conv_RREADY(conv_RREADY)
  );

  slv_axi_rd_reg_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_TRANS(2)) dut2 (
    .ACLK(ACLK), .sysReset(sysReset),
    .conv_ARID(conv_ARID), .conv_ARADDR(conv_ARADDR), .conv_ARLEN(conv_ARLEN), .conv_ARSIZE(conv_ARSIZE),
    .conv_ARBURST(conv_ARBURST), .conv_ARLOCK(conv_ARLOCK), .conv_ARPROT(conv_ARPROT), .conv_ARCACHE(conv_ARCACHE),
    .conv_ARVALID(m_ARVALID), .conv_ARREADY(m_ARREADY),
    .SLAVE_ARID(m_SARID), .SLAVE_ARADDR(m_SARADDR), .SLAVE_ARLEN(m_SARLEN), .SLAVE_ARSIZE(m_SARSIZE),
    .SLAVE_ARBURST(m_SARBURST), .SLAVE_ARLOCK(m_SARLOCK), .SLAVE_ARPROT(m_SARPROT), .SLAVE_ARCACHE(m_SARCACHE),
    .SLAVE_ARVALID(m_SARVALID), .SLAVE_ARREADY(m_SARREADY),
    .SLAVE_RID(SLAVE_RID), .SLAVE_RDATA(SLAVE_RDATA), .SLAVE_RRESP(SLAVE_RRESP), .SLAVE_RLAST(SLAVE_RLAST),
    .SLAVE_RVALID(m_SRVALID), .SLAVE_RREADY(m_SRREADY),
    .conv_RID(m_RID), .conv_RDATA(m_RDATA), .conv_RRESP(m_RRESP), .conv_RLAST(m_RLAST),
    .conv_RVALID(m_RVALID), .conv_RREADY(m_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // scoreboard: push on input handshake, pop and compare on output handshake
  always @(negedge ACLK) begin
    if (sysReset) begin
      ar_q.delete();
      r_q.delete();
    end else begin
      if (conv_ARVALID && conv_ARREADY) ar_q.push_back(ar_in);
      if (SLAVE_RVALID && SLAVE_RREADY) r_q.push_back(r_in);
      if (SLAVE_ARVALID && SLAVE_ARREADY) begin
        tot_n++;
        if (ar_q.size() == 0) $display("FAIL ar_sb: unexpected AR %h, nothing expected", ar_out);
        else begin
          ae = ar_q.pop_front();
          if (ar_out !== ae) $display("FAIL ar_sb: got %h exp %h", ar_out, ae); else pass_n++;
        end
      end
      if (conv_RVALID && conv_RREADY) begin
        tot_n++;
        r_delivered++;
        if (r_q.size() == 0) $display("FAIL r_sb: unexpected R %h, nothing expected", r_out);
        else begin
          re = r_q.pop_front();
          if (r_out !== re) $display("FAIL r_sb: got %h exp %h", r_out, re); else pass_n++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    sysReset = 1'b1;
    repeat (2) tick();
    tot_n++; if (SLAVE_ARVALID !== 1'b0) $display("FAIL rst_arvalid: got %b exp 0", SLAVE_ARVALID); else pass_n++;
    tot_n++; if (conv_RVALID !== 1'b0) $display("FAIL rst_rvalid: got %b exp 0", conv_RVALID); else pass_n++;
    tot_n++; if (conv_ARREADY !== 1'b1) $display("FAIL rst_arready: got %b exp 1", conv_ARREADY); else pass_n++;
    tot_n++; if (SLAVE_RREADY !== 1'b1) $display("FAIL rst_rready: got %b exp 1", SLAVE_RREADY); else pass_n++;
    tot_n++; if (dut.cnt_q !== 4'd0) $display("FAIL rst_cnt: got %0d exp 0", dut.cnt_q); else pass_n++;
    sysReset = 1'b0;
  endtask

  task automatic test_back_to_back();
    SLAVE_ARREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      conv_ARVALID = 1'b1;
      conv_ARID = IW'(i);
      conv_ARADDR = AW'(32'h100 + 32'h40 * i);
      conv_ARLEN = 8'd3;
      conv_ARSIZE = 3'd2;
      conv_ARBURST = 2'b01;
      conv_ARLOCK = 2'(i);
      conv_ARPROT = 3'(i + 1);
      conv_ARCACHE = 4'(i + 3);
      if (i == 0) begin
        tot_n++; if (SLAVE_ARVALID !== 1'b0) $display("FAIL b2b_latency: arvalid got %b exp 0 before first handshake", SLAVE_ARVALID); else pass_n++;
      end
      tot_n++; if (conv_ARREADY !== 1'b1) $display("FAIL b2b_arready%0d: got %b exp 1", i, conv_ARREADY); else pass_n++;
      tick();
      tot_n++; if (SLAVE_ARVALID !== 1'b1 || SLAVE_ARADDR !== AW'(32'h100 + 32'h40 * i))
        $display("FAIL b2b_out%0d: valid %b addr %h exp 1 %h", i, SLAVE_ARVALID, SLAVE_ARADDR, 32'h100 + 32'h40 * i); else pass_n++;
    end
    conv_ARVALID = 1'b0;
    tick();
    tot_n++; if (SLAVE_ARVALID !== 1'b0) $display("FAIL b2b_idle: got %b exp 0", SLAVE_ARVALID); else pass_n++;
    tot_n++; if (dut.cnt_q !== 4'd4) $display("FAIL b2b_cnt: got %0d exp 4", dut.cnt_q); else pass_n++;
  endtask

  task automatic test_backpressure();
    int j, d0;
    logic hs;
    j = 0;
    d0 = r_delivered;
    for (int c = 0; c < 12; c++) begin
      conv_RREADY = (c >= 5);
      SLAVE_RVALID = (j < 4);
      SLAVE_RID = '0;
      SLAVE_RDATA = 32'(32'hA0 + j);
      SLAVE_RRESP = 2'(j);
      SLAVE_RLAST = (j == 3);
      if (c == 2) begin
        tot_n++; if (SLAVE_RREADY !== 1'b0) $display("FAIL bp_rready_drop: got %b exp 0", SLAVE_RREADY); else pass_n++;
        tot_n++; if (j != 2) $display("FAIL bp_accepted: got %0d exp 2", j); else pass_n++;
      end
      if (c >= 2 && c < 5) begin
        tot_n++; if (conv_RVALID !== 1'b1 || conv_RDATA !== 32'hA0) $display("FAIL bp_hold: valid %b data %h exp 1 a0", conv_RVALID, conv_RDATA); else pass_n++;
      end
      hs = SLAVE_RVALID && SLAVE_RREADY;
      tick();
      if (hs) j++;
    end
    SLAVE_RVALID = 1'b0;
    tot_n++; if (j != 4) $display("FAIL bp_sent: got %0d exp 4", j); else pass_n++;
    tot_n++; if (r_delivered - d0 != 4) $display("FAIL bp_delivered: got %0d exp 4", r_delivered - d0); else pass_n++;
    tot_n++; if (dut.cnt_q !== 4'd3) $display("FAIL bp_cnt: got %0d exp 3", dut.cnt_q); else pass_n++;
  endtask

  task automatic test_interleave();
    int d0;
    d0 = r_delivered;
    conv_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SLAVE_RVALID = 1'b1;
      SLAVE_RID = (i % 2 == 0) ? IW'(1) : IW'(0);
      SLAVE_RDATA = 32'(32'hB0 + i);
      SLAVE_RRESP = 2'(3 - i);
      SLAVE_RLAST = (i >= 2);
      tot_n++; if (SLAVE_RREADY !== 1'b1) $display("FAIL il_rready%0d: got %b exp 1", i, SLAVE_RREADY); else pass_n++;
      tick();
    end
    SLAVE_RVALID = 1'b0;
    repeat (3) tick();
    tot_n++; if (r_delivered - d0 != 4) $display("FAIL il_delivered: got %0d exp 4", r_delivered - d0); else pass_n++;
    tot_n++; if (dut.cnt_q !== 4'd1) $display("FAIL il_cnt: got %0d exp 1", dut.cnt_q); else pass_n++;
    tot_n++; if (ar_q.size() != 0 || r_q.size() != 0) $display("FAIL il_sb_empty: ar %0d r %0d exp 0 0", ar_q.size(), r_q.size()); else pass_n++;
  endtask

  task automatic test_limit();
    m_SARREADY = 1'b1;
    m_RREADY = 1'b1;
    m_ARVALID = 1'b1;
    tot_n++; if (m_ARREADY !== 1'b1) $display("FAIL lim_rdy0: got %b exp 1", m_ARREADY); else pass_n++;
    tick();
    tot_n++; if (m_ARREADY !== 1'b1 || dut2.cnt_q !== 2'd1) $display("FAIL lim_rdy1: rdy %b cnt %0d exp 1 1", m_ARREADY, dut2.cnt_q); else pass_n++;
    tick();
    tot_n++; if (m_ARREADY !== 1'b0 || dut2.cnt_q !== 2'd2) $display("FAIL lim_full: rdy %b cnt %0d exp 0 2", m_ARREADY, dut2.cnt_q); else pass_n++;
    tick();
    tot_n++; if (m_ARREADY !== 1'b0 || dut2.cnt_q !== 2'd2) $display("FAIL lim_hold: rdy %b cnt %0d exp 0 2", m_ARREADY, dut2.cnt_q); else pass_n++;
    SLAVE_RID = '0;
    SLAVE_RDATA = 32'hC0;
    SLAVE_RRESP = 2'b00;
    SLAVE_RLAST = 1'b1;
    m_SRVALID = 1'b1;
    tick();
    m_SRVALID = 1'b0;
    tot_n++; if (m_RVALID !== 1'b1 || m_RLAST !== 1'b1) $display("FAIL lim_rbeat: valid %b last %b exp 1 1", m_RVALID, m_RLAST); else pass_n++;
    tick();
    tot_n++; if (m_ARREADY !== 1'b1) $display("FAIL lim_reassert: got %b exp 1", m_ARREADY); else pass_n++;
    tick();
    tot_n++; if (m_ARREADY !== 1'b0 || dut2.cnt_q !== 2'd2) $display("FAIL lim_third: rdy %b cnt %0d exp 0 2", m_ARREADY, dut2.cnt_q); else pass_n++;
    m_ARVALID = 1'b0;
  endtask

  task automatic test_simultaneous();
    m_SRVALID = 1'b1;
    tick();
    m_SRVALID = 1'b0;
    tick();
    tot_n++; if (dut2.cnt_q !== 2'd1) $display("FAIL sim_pre: cnt %0d exp 1", dut2.cnt_q); else pass_n++;
    m_SRVALID = 1'b1;
    tick();
    m_SRVALID = 1'b0;
    m_ARVALID = 1'b1;
    tot_n++; if (m_ARREADY !== 1'b1 || m_RVALID !== 1'b1) $display("FAIL sim_setup: ardy %b rvalid %b exp 1 1", m_ARREADY, m_RVALID); else pass_n++;
    tick();
    tot_n++; if (dut2.cnt_q !== 2'd1 || m_ARREADY !== 1'b1) $display("FAIL sim_both: cnt %0d rdy %b exp 1 1", dut2.cnt_q, m_ARREADY); else pass_n++;
    m_ARVALID = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    SLAVE_ARREADY = 1'b0;
    conv_RREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      conv_ARVALID = (i < 2);
      conv_ARID = IW'(i);
      conv_ARADDR = AW'(32'h800 + i);
      SLAVE_RVALID = 1'b1;
      SLAVE_RID = IW'(i);
      SLAVE_RDATA = 32'(32'hD0 + i);
      SLAVE_RLAST = 1'b0;
      tick();
    end
    conv_ARVALID = 1'b0;
    SLAVE_RVALID = 1'b0;
    tot_n++; if (SLAVE_ARVALID !== 1'b1 || conv_RVALID !== 1'b1 || conv_ARREADY !== 1'b0 || SLAVE_RREADY !== 1'b0)
      $display("FAIL rm_loaded: arv %b rv %b ardy %b rrdy %b exp 1 1 0 0", SLAVE_ARVALID, conv_RVALID, conv_ARREADY, SLAVE_RREADY); else pass_n++;
    tot_n++; if (dut.cnt_q !== 4'd3) $display("FAIL rm_cnt_pre: got %0d exp 3", dut.cnt_q); else pass_n++;
    sysReset = 1'b1;
    tick();
    tot_n++; if (SLAVE_ARVALID !== 1'b0) $display("FAIL rm_arvalid: got %b exp 0", SLAVE_ARVALID); else pass_n++;
    tot_n++; if (conv_RVALID !== 1'b0) $display("FAIL rm_rvalid: got %b exp 0", conv_RVALID); else pass_n++;
    tot_n++; if (conv_ARREADY !== 1'b1 || SLAVE_RREADY !== 1'b1) $display("FAIL rm_ready: ardy %b rrdy %b exp 1 1", conv_ARREADY, SLAVE_RREADY); else pass_n++;
    tot_n++; if (dut.cnt_q !== 4'd0) $display("FAIL rm_cnt: got %0d exp 0", dut.cnt_q); else pass_n++;
    sysReset = 1'b0;
    SLAVE_ARREADY = 1'b1;
    conv_RREADY = 1'b1;
    tick();
  endtask

  initial begin
    sysReset = 1'b1;
    conv_ARVALID = 1'b0; conv_ARID = '0; conv_ARADDR = '0; conv_ARLEN = '0; conv_ARSIZE = '0;
    conv_ARBURST = '0; conv_ARLOCK = '0; conv_ARPROT = '0; conv_ARCACHE = '0;
    SLAVE_ARREADY = 1'b0; SLAVE_RVALID = 1'b0; SLAVE_RID = '0; SLAVE_RDATA = '0; SLAVE_RRESP = '0; SLAVE_RLAST = 1'b0;
    conv_RREADY = 1'b0;
    m_ARVALID = 1'b0; m_SARREADY = 1'b0; m_SRVALID = 1'b0; m_RREADY = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_interleave();
    test_limit();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
